// File: rtl/sat_window_accum_if.sv
// Handshake bundle between the saturating window accumulator and its neighbours.
// The master side produces samples and consumes results; the slave side is the accumulator.
interface sat_window_accum_if #(
  parameter int N  = 8,
  parameter int CW = 3
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_data;
  logic                in_ov;
  logic                in_uv;
  logic                out_valid;
  logic                out_ready;
  logic signed [N-1:0] out_sum;
  logic [CW-1:0]       out_sat_cnt;

  modport master (
    output in_valid, in_data, in_ov, in_uv, out_ready,
    input  in_ready, out_valid, out_sum, out_sat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ov, in_uv, out_ready,
    output in_ready, out_valid, out_sum, out_sat_cnt
  );
endinterface

// File: rtl/sat_window_accum.sv
// Sums windows of LEN signed samples with saturation at every step, counts
// saturation events per window and offers each window result on a valid/ready port.
module sat_window_accum #(
  parameter int N   = 8,
  parameter int LEN = 4,
  parameter int CW  = $clog2(LEN + 1)
) (
  input logic               clk,
  input logic               rst,
  sat_window_accum_if.slave bus
);
  localparam logic signed [N:0] MaxVal  = {2'b00, {(N-1){1'b1}}};
  localparam logic signed [N:0] MinVal  = {2'b11, {(N-1){1'b0}}};
  localparam logic [CW-1:0]     LastIdx = CW'(LEN - 1);

  logic signed [N-1:0] acc_q, acc_d;
  logic [CW-1:0]       sampleCnt_q, sampleCnt_d;
  logic [CW-1:0]       evCnt_q, evCnt_d;
  logic                outValid_q, outValid_d;
  logic signed [N-1:0] outSum_q, outSum_d;
  logic [CW-1:0]       outSatCnt_q, outSatCnt_d;

  logic                inReady;
  logic                accept;
  logic                fire;
  logic                closeWin;
  logic signed [N:0]   stepSum;
  logic signed [N-1:0] accNext;
  logic                accSat;
  logic                sampleEvent;
  logic [CW-1:0]       evNext;

  // A new sample can enter whenever the result register is empty or draining.
  assign inReady = !outValid_q || bus.out_ready;

  assign bus.in_ready    = inReady;
  assign bus.out_valid   = outValid_q;
  assign bus.out_sum     = outSum_q;
  assign bus.out_sat_cnt = outSatCnt_q;

  always_comb begin
    accept   = bus.in_valid && inReady;
    fire     = outValid_q && bus.out_ready;
    stepSum  = $signed({acc_q[N-1], acc_q}) + $signed({bus.in_data[N-1], bus.in_data});
    accNext  = stepSum[N-1:0];
    accSat   = 1'b0;
    if (stepSum > MaxVal) begin
      accNext = MaxVal[N-1:0];
      accSat  = 1'b1;
    end else if (stepSum < MinVal) begin
      accNext = MinVal[N-1:0];
      accSat  = 1'b1;
    end
    sampleEvent = bus.in_ov || bus.in_uv || accSat;
    evNext      = evCnt_q + CW'(sampleEvent);
    closeWin    = accept && (sampleCnt_q == LastIdx);

    acc_d       = acc_q;
    sampleCnt_d = sampleCnt_q;
    evCnt_d     = evCnt_q;
    outValid_d  = outValid_q;
    outSum_d    = outSum_q;
    outSatCnt_d = outSatCnt_q;

    if (fire) begin
      outValid_d = 1'b0;
    end
    // A closing accept overrides the drain so back-to-back results have no bubble.
    if (accept) begin
      if (closeWin) begin
        outSum_d    = accNext;
        outSatCnt_d = evNext;
        outValid_d  = 1'b1;
        acc_d       = '0;
        sampleCnt_d = '0;
        evCnt_d     = '0;
      end else begin
        acc_d       = accNext;
        sampleCnt_d = sampleCnt_q + CW'(1);
        evCnt_d     = evNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      sampleCnt_q <= '0;
      evCnt_q     <= '0;
      outValid_q  <= 1'b0;
      outSum_q    <= '0;
      outSatCnt_q <= '0;
    end else begin
      acc_q       <= acc_d;
      sampleCnt_q <= sampleCnt_d;
      evCnt_q     <= evCnt_d;
      outValid_q  <= outValid_d;
      outSum_q    <= outSum_d;
      outSatCnt_q <= outSatCnt_d;
    end
  end
endmodule

// File: tb/tb_sat_window_accum.sv
// Bench for sat_window_accum: a LEN=4 and a LEN=1 instance checked every cycle
// against a queue-based window model, plus hand-computed result checks.
module tb_sat_window_accum;
  localparam int N    = 8;
  localparam int MaxV = 127;
  localparam int MinV = -128;

  logic clk;
  logic rst;
  bit   checking;
  int   vectors;
  int   miscompares;

  sat_window_accum_if #(.N(N), .CW(3)) bus4 ();
  sat_window_accum_if #(.N(N), .CW(1)) bus1 ();

  sat_window_accum #(.N(N), .LEN(4), .CW(3)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  sat_window_accum #(.N(N), .LEN(1), .CW(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Saturating window sum written straight from the arithmetic rules.
  function automatic void windowResult(input int d[$], input bit f[$], output int sum, output int cnt);
    sum = 0;
    cnt = 0;
    for (int i = 0; i < d.size(); i++) begin
      int t;
      bit sat;
      t   = sum + d[i];
      sat = 1'b0;
      if (t > MaxV) begin
        sum = MaxV;
        sat = 1'b1;
      end else if (t < MinV) begin
        sum = MinV;
        sat = 1'b1;
      end else begin
        sum = t;
      end
      if (f[i] || sat) cnt++;
    end
  endfunction

  int m4Valid, m4Sum, m4Cnt;
  int w4D[$];
  bit w4F[$];
  int m1Valid, m1Sum, m1Cnt;
  int w1D[$];
  bit w1F[$];

  always @(posedge clk) begin
    if (rst) begin
      m4Valid = 0;
      m4Sum   = 0;
      m4Cnt   = 0;
      w4D.delete();
      w4F.delete();
    end else begin
      bit takeIt;
      takeIt = bus4.in_valid && (!m4Valid || bus4.out_ready);
      if (m4Valid && bus4.out_ready) m4Valid = 0;
      if (takeIt) begin
        w4D.push_back(int'($signed(bus4.in_data)));
        w4F.push_back(bus4.in_ov || bus4.in_uv);
        if (w4D.size() == 4) begin
          windowResult(w4D, w4F, m4Sum, m4Cnt);
          m4Valid = 1;
          w4D.delete();
          w4F.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m1Valid = 0;
      m1Sum   = 0;
      m1Cnt   = 0;
      w1D.delete();
      w1F.delete();
    end else begin
      bit takeIt;
      takeIt = bus1.in_valid && (!m1Valid || bus1.out_ready);
      if (m1Valid && bus1.out_ready) m1Valid = 0;
      if (takeIt) begin
        w1D.push_back(int'($signed(bus1.in_data)));
        w1F.push_back(bus1.in_ov || bus1.in_uv);
        windowResult(w1D, w1F, m1Sum, m1Cnt);
        m1Valid = 1;
        w1D.delete();
        w1F.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("valid4", int'(bus4.out_valid), m4Valid);
      checkOutput("ready4", int'(bus4.in_ready), int'(!m4Valid || bus4.out_ready));
      if (m4Valid != 0) begin
        checkOutput("sum4", int'($signed(bus4.out_sum)), m4Sum);
        checkOutput("cnt4", int'(bus4.out_sat_cnt), m4Cnt);
      end
      checkOutput("valid1", int'(bus1.out_valid), m1Valid);
      checkOutput("ready1", int'(bus1.in_ready), int'(!m1Valid || bus1.out_ready));
      if (m1Valid != 0) begin
        checkOutput("sum1", int'($signed(bus1.out_sum)), m1Sum);
        checkOutput("cnt1", int'(bus1.out_sat_cnt), m1Cnt);
      end
    end
  end

  task automatic applyStimulus(input int d, input bit ov, input bit uv);
    bus4.in_valid = 1'b1;
    bus4.in_data  = d[N-1:0];
    bus4.in_ov    = ov;
    bus4.in_uv    = uv;
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    bus4.in_ov    = 1'b0;
    bus4.in_uv    = 1'b0;
  endtask

  task automatic checkResult(input string name, input int expSum, input int expCnt, input bit oneCycle);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus4.out_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: out_valid never rose within 20 cycles", name);
    end else begin
      checkOutput({name, "_sum"}, int'($signed(bus4.out_sum)), expSum);
      checkOutput({name, "_cnt"}, int'(bus4.out_sat_cnt), expCnt);
      if (oneCycle) begin
        @(negedge clk);
        checkOutput({name, "_drop"}, int'(bus4.out_valid), 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors       = 0;
    miscompares   = 0;
    checking      = 1'b0;
    rst           = 1'b1;
    bus4.in_valid = 1'b0;
    bus4.in_data  = '0;
    bus4.in_ov    = 1'b0;
    bus4.in_uv    = 1'b0;
    bus4.out_ready = 1'b1;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    bus1.in_ov    = 1'b0;
    bus1.in_uv    = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    checking = 1'b1;

    @(negedge clk);
    checkOutput("rst_valid", int'(bus4.out_valid), 0);
    checkOutput("rst_sum", int'($signed(bus4.out_sum)), 0);
    checkOutput("rst_cnt", int'(bus4.out_sat_cnt), 0);
    checkOutput("rst_ready", int'(bus4.in_ready), 1);

    applyStimulus(10, 0, 0);
    applyStimulus(20, 0, 0);
    applyStimulus(-5, 0, 0);
    applyStimulus(7, 0, 0);
    checkResult("ordinary", 32, 0, 1'b1);

    applyStimulus(100, 0, 0);
    applyStimulus(100, 0, 0);
    applyStimulus(100, 0, 0);
    applyStimulus(-50, 0, 0);
    checkResult("possat", 77, 2, 1'b1);

    applyStimulus(-100, 0, 1);
    applyStimulus(-100, 0, 0);
    applyStimulus(-1, 0, 0);
    applyStimulus(0, 0, 0);
    checkResult("negsat", -128, 3, 1'b1);

    // Stall a finished window while a sample waits upstream.
    bus4.out_ready = 1'b0;
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(1, 0, 0);
    bus4.in_valid = 1'b1;
    bus4.in_data  = 8'sd9;
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_valid", int'(bus4.out_valid), 1);
      checkOutput("stall_ready", int'(bus4.in_ready), 0);
      checkOutput("stall_sum", int'($signed(bus4.out_sum)), 4);
    end
    @(posedge clk);
    #1;
    bus4.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release_ready", int'(bus4.in_ready), 1);
    @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    applyStimulus(2, 0, 0);
    applyStimulus(3, 0, 0);
    applyStimulus(4, 0, 0);
    checkResult("after_stall", 18, 0, 1'b1);

    applyStimulus(50, 0, 0);
    applyStimulus(60, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", int'(bus4.out_valid), 0);
    checkOutput("midrst_sum", int'($signed(bus4.out_sum)), 0);
    checkOutput("midrst_cnt", int'(bus4.out_sat_cnt), 0);
    checkOutput("midrst_ready", int'(bus4.in_ready), 1);
    applyStimulus(1, 0, 0);
    applyStimulus(2, 0, 0);
    applyStimulus(3, 0, 0);
    applyStimulus(4, 0, 0);
    checkResult("post_rst", 10, 0, 1'b1);

    // LEN=1 streaming: one result per cycle with no bubbles.
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'sd5;
    @(posedge clk);
    #1;
    bus1.in_data = -8'sd3;
    bus1.in_ov   = 1'b1;
    @(negedge clk);
    checkOutput("len1_valid_a", int'(bus1.out_valid), 1);
    checkOutput("len1_sum_a", int'($signed(bus1.out_sum)), 5);
    checkOutput("len1_cnt_a", int'(bus1.out_sat_cnt), 0);
    @(posedge clk);
    #1;
    bus1.in_data = 8'sd127;
    bus1.in_ov   = 1'b0;
    @(negedge clk);
    checkOutput("len1_valid_b", int'(bus1.out_valid), 1);
    checkOutput("len1_sum_b", int'($signed(bus1.out_sum)), -3);
    checkOutput("len1_cnt_b", int'(bus1.out_sat_cnt), 1);
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("len1_valid_c", int'(bus1.out_valid), 1);
    checkOutput("len1_sum_c", int'($signed(bus1.out_sum)), 127);
    checkOutput("len1_cnt_c", int'(bus1.out_sat_cnt), 0);
    @(negedge clk);
    checkOutput("len1_drop", int'(bus1.out_valid), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
